// File: rtl/ap_arb_pkg.sv
// Shared types and default parameters for the two-channel ap_fifo arbiter.
package ap_arb_pkg;

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} arb_state_t;

    localparam int DEF_DATA_W    = 128;
    localparam int DEF_BURST_LEN = 16;
    localparam int DEF_TAG_DEPTH = 32;

endpackage

// File: rtl/ap_arb_tag_fifo.sv
// 1-bit channel tag FIFO: records which channel owns each word inside the shared IP.
module ap_arb_tag_fifo #(
    parameter int DEPTH = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic push_tag,
    input  logic pop,
    output logic head_tag,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             do_push, do_pop;

    // A pop frees its slot in the same cycle, so a push is still taken when full.
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign head_tag = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_tag;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ap_fifo_ch_arbiter.sv
// Shares one ap_fifo-streaming IP between two channels with round-robin bursts.
// Define AP_ARB_CNT_EN to add per-channel accepted/delivered word counters.
module ap_fifo_ch_arbiter
    import ap_arb_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int BURST_LEN = DEF_BURST_LEN,
    parameter int TAG_DEPTH = DEF_TAG_DEPTH
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic [DATA_W-1:0] in_dout_0,
    input  logic [DATA_W-1:0] in_dout_1,
    input  logic              in_empty_n_0,
    input  logic              in_empty_n_1,
    output logic              in_read_0,
    output logic              in_read_1,
    output logic [DATA_W-1:0] out_din_0,
    output logic [DATA_W-1:0] out_din_1,
    input  logic              out_full_n_0,
    input  logic              out_full_n_1,
    output logic              out_write_0,
    output logic              out_write_1,
    output logic [DATA_W-1:0] ip_in_dout,
    output logic              ip_in_empty_n,
    input  logic              ip_in_read,
    input  logic [DATA_W-1:0] ip_out_din,
    output logic              ip_out_full_n,
    input  logic              ip_out_write,
    output logic              cur_ch,
    output logic              err_orphan
`ifdef AP_ARB_CNT_EN
    ,
    output logic [31:0]       cnt_in_0,
    output logic [31:0]       cnt_in_1,
    output logic [31:0]       cnt_out_0,
    output logic [31:0]       cnt_out_1
`endif
);
    localparam int BW = $clog2(BURST_LEN + 1);

    arb_state_t  state;
    logic        last_ch;
    logic [BW-1:0] beat_cnt;
    logic [1:0]  empty_n_v, full_n_v;
    logic        tag_full, tag_empty, head_tag;
    logic        accept, deliver;

    assign empty_n_v = {in_empty_n_1, in_empty_n_0};
    assign full_n_v  = {out_full_n_1, out_full_n_0};

    // Input side: only the granted channel is visible, throttled by tag space.
    assign ip_in_dout    = cur_ch ? in_dout_1 : in_dout_0;
    assign ip_in_empty_n = (state == GRANT) & empty_n_v[cur_ch] & ~tag_full;
    assign accept        = ip_in_read & ip_in_empty_n;
    assign in_read_0     = accept & ~cur_ch;
    assign in_read_1     = accept & cur_ch;

    // Output side: the oldest tag steers the word, so only its channel can stall the IP.
    assign ip_out_full_n = ~tag_empty & full_n_v[head_tag];
    assign deliver       = ip_out_write & ip_out_full_n;
    assign out_write_0   = deliver & ~head_tag;
    assign out_write_1   = deliver & head_tag;
    assign out_din_0     = ip_out_din;
    assign out_din_1     = ip_out_din;

    ap_arb_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
        .clk      (ap_clk),
        .rst_n    (ap_rst_n),
        .push     (accept),
        .push_tag (cur_ch),
        .pop      (deliver),
        .head_tag (head_tag),
        .full     (tag_full),
        .empty    (tag_empty)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state    <= IDLE;
            cur_ch   <= 1'b0;
            last_ch  <= 1'b1;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|empty_n_v) begin
                        state    <= GRANT;
                        beat_cnt <= '0;
                        if (&empty_n_v) begin
                            cur_ch  <= ~last_ch;
                            last_ch <= ~last_ch;
                        end else begin
                            cur_ch  <= empty_n_v[1];
                            last_ch <= empty_n_v[1];
                        end
                    end
                end
                GRANT: begin
                    if ((accept && beat_cnt == BW'(BURST_LEN - 1)) ||
                        (!empty_n_v[cur_ch] && !accept)) begin
                        state    <= IDLE;
                        beat_cnt <= '0;
                    end else if (accept) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n)
            err_orphan <= 1'b0;
        else if (ip_out_write && tag_empty)
            err_orphan <= 1'b1;
    end

`ifdef AP_ARB_CNT_EN
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            cnt_in_0  <= '0;
            cnt_in_1  <= '0;
            cnt_out_0 <= '0;
            cnt_out_1 <= '0;
        end else begin
            if (in_read_0)   cnt_in_0  <= cnt_in_0 + 32'd1;
            if (in_read_1)   cnt_in_1  <= cnt_in_1 + 32'd1;
            if (out_write_0) cnt_out_0 <= cnt_out_0 + 32'd1;
            if (out_write_1) cnt_out_1 <= cnt_out_1 + 32'd1;
        end
    end
`endif

endmodule
